cmp_stream_packer: RTL and testbench
====================================

# cmp_stream_packer

Streaming front-end for the 3-bit-select predicate comparator path. It accepts operand pairs with an opcode over a valid/ready handshake and registers them in an operand stage. It evaluates the selected predicate and packs the 1-bit results LSB-first into PACK-bit mask words. Completed words go to the downstream consumer over a second valid/ready handshake, with a result count and a frame-end flag.

## Interface
- N, 8, operand width in bits; operands are unsigned.
- PACK, 8, number of results per output mask word; must be ≥ 2.
- CW, $clog2(PACK+1), width of the count fields (derived; not for override).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_sel  in  3  predicate: 0 const0, 1 const1, 2 a==b, 3 a!=b, 4 a>=b, 5 a<=b, 6 a<b, 7 a>b.
- in_a  in  N  first operand.
- in_b  in  N  second operand.
- in_last  in  1  final beat of a frame; forces a partial word out.
- out_valid  out  1  mask word valid.
- out_ready  in  1  consumer accepts the word.
- out_mask  out  PACK  packed results; bit i is the i-th result of the word.
- out_len  out  CW  number of valid bits in out_mask, 1..PACK.
- out_count  out  CW  number of set bits among the valid bits.
- out_last  out  1  word closes a frame.

## Operation
- Beat accepted on an edge where in_valid && in_ready.
- Pipeline stages:
  - S1, operand register: holds sel, a, b, last and s1_valid.
  - S2, packer: holds accumulator acc[PACK-1:0], fill index idx (0..PACK-1) and running popcount.
  - OUT, output register: holds mask, len, count, last and out_valid.
- S1 advances into S2 when s1_valid and one of the following holds:
  - the beat does not complete a word, or
  - OUT is empty, or
  - OUT is draining this cycle (out_valid && out_ready).
- in_ready = !s1_valid || s1_advance. This is combinational from out_ready; no combinational path from in_valid.
- A beat completes a word when idx == PACK-1 or last == 1.
- On advance:
  - Result r is written to acc[idx].
  - If the beat completes a word: OUT is loaded with mask = acc with r merged (bits ≥ len forced 0), len = idx+1, count = popcount, last = S1 last. acc, idx and popcount then clear.
  - Otherwise idx increments and popcount adds r.
- OUT holds its contents stable while out_valid && !out_ready.
- Simultaneous drain and load in one cycle: the new word replaces the drained one and out_valid stays 1.
- A word of exactly PACK beats whose final beat has in_last set emits one word with len = PACK and out_last = 1. No empty word follows.
- Reset mid-frame or mid-backpressure discards S1, the partial accumulator and OUT. Nothing is emitted.
- Reset values:
  - in_ready = 1.
  - out_valid = 0.
  - out_mask, out_len, out_count and out_last = 0.
  - idx = 0.

## Timing
- Beat accepted at edge t is in S1 after t. It reaches S2/OUT at edge t+1.
- out_valid is asserted after edge t+1 for a completing beat. Minimum latency from acceptance to out_valid is 2 cycles.
- Sustained throughput is 1 beat/cycle when out_ready = 1.
- With out_ready held low, the block accepts at most PACK+1 further beats before in_ready drops: PACK−1 into the accumulator, then one completing beat stalled in S1, after a full OUT.
- in_ready recovers in the same cycle out_ready rises.

## Configuration
- CMP_PACK_STATS_EN defined adds the following outputs:
  - stat_words, out, 16 bits: words handed off.
  - stat_true, out, 16 bits: total set result bits handed off.
- Both counters count at OUT handshake, saturate at 16'hFFFF, and reset to 0.
- CMP_PACK_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- PACK=8. Eight beats sel=2 with a==b on beats 0, 3 and 7, in_last on beat 7, out_ready=1 → one word: mask=8'h89, len=8, count=3, last=1, out_valid 2 cycles after the beat-7 accept.
- Three beats sel=7 with (5,3), (3,5), (9,9), last on beat 2 → mask=8'h01, len=3, count=1, last=1. Upper mask bits are 0.
- Opcode sweep: a=4, b=4 then a=3, b=4, each with sel 0..7 → results 0,1,1,0,1,1,0,0 and 0,1,0,1,0,1,1,0. Words 8'h36 and 8'h6A.
- out_ready held low during a continuous stream:
  - in_ready drops after exactly PACK+1 further accepts.
  - OUT stays stable throughout.
  - Releasing out_ready yields the words in order with none lost or duplicated.
- rst asserted for one cycle after 5 of 8 beats → no output word. The next frame packs from bit 0.
- With CMP_PACK_STATS_EN: 3 words containing 3, 1 and 1 set bits → stat_words=3, stat_true=5. The counters saturate when preloaded via a long run.

Source files
------------

// File: rtl/cmp_stream_packer.sv
// Predicate comparator front-end: registers operand beats, evaluates the selected
// predicate and packs results LSB-first into mask words. Optional CMP_PACK_STATS_EN adds handoff counters.
module cmp_stream_packer #(
  parameter int N = 8,
  parameter int PACK = 8,
  localparam int CW = $clog2(PACK + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_sel,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PACK-1:0] out_mask,
  output logic [CW-1:0]   out_len,
  output logic [CW-1:0]   out_count,
  output logic            out_last
`ifdef CMP_PACK_STATS_EN
  ,
  output logic [15:0]     stat_words,
  output logic [15:0]     stat_true
`endif
);

  localparam int IW = (PACK > 1) ? $clog2(PACK) : 1;

  logic            s1_valid_reg;
  logic [2:0]      s1_sel_reg;
  logic [N-1:0]    s1_a_reg;
  logic [N-1:0]    s1_b_reg;
  logic            s1_last_reg;

  logic [PACK-1:0] acc_reg;
  logic [IW-1:0]   idx_reg;
  logic [CW-1:0]   pop_reg;

  logic            out_valid_reg;
  logic [PACK-1:0] out_mask_reg;
  logic [CW-1:0]   out_len_reg;
  logic [CW-1:0]   out_count_reg;
  logic            out_last_reg;

  logic            result;
  logic            completes;
  logic            s1_advance;
  logic [PACK-1:0] merged;
  logic [CW-1:0]   pop_next;
  logic [CW-1:0]   len_next;

  always_comb begin
    result = 1'b0;
    case (s1_sel_reg)
      3'd0: result = 1'b0;
      3'd1: result = 1'b1;
      3'd2: result = (s1_a_reg == s1_b_reg);
      3'd3: result = (s1_a_reg != s1_b_reg);
      3'd4: result = (s1_a_reg >= s1_b_reg);
      3'd5: result = (s1_a_reg <= s1_b_reg);
      3'd6: result = (s1_a_reg <  s1_b_reg);
      default: result = (s1_a_reg > s1_b_reg);
    endcase
  end

  // Only a completing beat needs room in OUT; all others can always advance.
  assign completes  = (idx_reg == IW'(PACK - 1)) || s1_last_reg;
  assign s1_advance = s1_valid_reg && (!completes || !out_valid_reg || out_ready);
  assign in_ready   = !s1_valid_reg || s1_advance;

  assign pop_next = pop_reg + CW'(result);
  assign len_next = CW'(idx_reg) + CW'(1);

  // Bits above the fill index are forced to zero so partial words are clean.
  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_merge
      assign merged[gi] = (gi == int'(idx_reg)) ? result :
                          ((gi < int'(idx_reg)) ? acc_reg[gi] : 1'b0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_sel_reg    <= '0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_last_reg   <= 1'b0;
      acc_reg       <= '0;
      idx_reg       <= '0;
      pop_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_mask_reg  <= '0;
      out_len_reg   <= '0;
      out_count_reg <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid_reg <= 1'b1;
        s1_sel_reg   <= in_sel;
        s1_a_reg     <= in_a;
        s1_b_reg     <= in_b;
        s1_last_reg  <= in_last;
      end else if (s1_advance) begin
        s1_valid_reg <= 1'b0;
      end

      if (s1_advance && completes) begin
        out_valid_reg <= 1'b1;
        out_mask_reg  <= merged;
        out_len_reg   <= len_next;
        out_count_reg <= pop_next;
        out_last_reg  <= s1_last_reg;
        acc_reg       <= '0;
        idx_reg       <= '0;
        pop_reg       <= '0;
      end else begin
        if (out_valid_reg && out_ready) begin
          out_valid_reg <= 1'b0;
        end
        if (s1_advance) begin
          acc_reg <= merged;
          idx_reg <= idx_reg + IW'(1);
          pop_reg <= pop_next;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_mask  = out_mask_reg;
  assign out_len   = out_len_reg;
  assign out_count = out_count_reg;
  assign out_last  = out_last_reg;

`ifdef CMP_PACK_STATS_EN
  logic [15:0] stat_words_reg;
  logic [15:0] stat_true_reg;
  logic [16:0] true_sum;

  assign true_sum = {1'b0, stat_true_reg} + 17'(out_count_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words_reg <= '0;
      stat_true_reg  <= '0;
    end else if (out_valid_reg && out_ready) begin
      if (stat_words_reg != 16'hFFFF) begin
        stat_words_reg <= stat_words_reg + 16'd1;
      end
      stat_true_reg <= true_sum[16] ? 16'hFFFF : true_sum[15:0];
    end
  end

  assign stat_words = stat_words_reg;
  assign stat_true  = stat_true_reg;
`endif

endmodule

// File: tb/tb_cmp_stream_packer.sv
// Self-checking bench for cmp_stream_packer: directed vectors plus randomized streams
// checked against a queue-based packing model.
module tb_cmp_stream_packer;
  localparam int N = 8;
  localparam int PACK = 8;
  localparam int CW = $clog2(PACK + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_sel = '0;
  logic [N-1:0]    in_a = '0;
  logic [N-1:0]    in_b = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [PACK-1:0] out_mask;
  logic [CW-1:0]   out_len;
  logic [CW-1:0]   out_count;
  logic            out_last;
`ifdef CMP_PACK_STATS_EN
  logic [15:0]     stat_words;
  logic [15:0]     stat_true;
`endif

  cmp_stream_packer #(.N(N), .PACK(PACK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_len(out_len), .out_count(out_count), .out_last(out_last)
`ifdef CMP_PACK_STATS_EN
    , .stat_words(stat_words), .stat_true(stat_true)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PACK-1:0] mask;
    logic [CW-1:0]   len;
    logic [CW-1:0]   cnt;
    logic            last;
  } word_t;

  word_t exp_q[$];
  word_t got_q[$];
  bit    cur_bits[$];
  int    errors = 0;
  int    checks = 0;
  int    stall_cycles = 0;
  bit    bp_mode = 0;

  function automatic bit pred(input logic [2:0] sel, input int a, input int b);
    case (sel)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return a == b;
      3'd3: return a != b;
      3'd4: return a >= b;
      3'd5: return a <= b;
      3'd6: return a < b;
      default: return a > b;
    endcase
  endfunction

  // Model: collect results of a frame; a word closes on a full word or a last beat.
  function automatic void model_beat(input bit r, input bit last);
    word_t w;
    cur_bits.push_back(r);
    if (last || cur_bits.size() == PACK) begin
      w = '0;
      foreach (cur_bits[i]) begin
        w.mask[i] = cur_bits[i];
        w.cnt = w.cnt + CW'(cur_bits[i]);
      end
      w.len = CW'(cur_bits.size());
      w.last = last;
      exp_q.push_back(w);
      cur_bits.delete();
    end
  endfunction

  // Inputs only change just after rising edges, so the negedge view predicts the next handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back({out_mask, out_len, out_count, out_last});
  end

  task automatic send_beat(input logic [2:0] sel, input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit last);
    bit ok = 0;
    in_valid = 1'b1; in_sel = sel; in_a = a; in_b = b; in_last = last;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      stall_cycles++;
      @(posedge clk); #1;
      if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%0b required 1 within 500 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(pred(sel, int'(a), int'(b)), last);
    if (bp_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    bit ok = 0;
    bp_mode = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (got_q.size() >= exp_q.size() && !out_valid) begin ok = 1; break; end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic clear_queues();
    exp_q.delete(); got_q.delete(); cur_bits.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    if (out_mask !== '0) begin errors++; $display("FAIL reset_out_mask: got %h required 00", out_mask); end
    if (out_len !== '0) begin errors++; $display("FAIL reset_out_len: got %0d required 0", out_len); end
    if (out_count !== '0) begin errors++; $display("FAIL reset_out_count: got %0d required 0", out_count); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b required 0", out_last); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_eq_word();
    logic [N-1:0] a, b;
    clear_queues();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = N'($urandom);
      b = (i == 0 || i == 3 || i == 7) ? a : (a ^ N'($urandom_range(1, 255)));
      send_beat(3'd2, a, b, i == 7);
    end
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL eq_latency_early: out_valid=%0b required 0", out_valid); end
    @(posedge clk); #1;
    if ({out_valid, out_mask, out_len, out_count, out_last} !== {1'b1, 8'h89, 4'd8, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL eq_word: valid=%0b mask=%h len=%0d cnt=%0d last=%0b required 1/89/8/3/1",
               out_valid, out_mask, out_len, out_count, out_last);
    end
    drain();
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL eq_word_count: got %0d words required 1", got_q.size()); end
    $display("eq word: mask=%h len=%0d", out_mask, out_len);
  endtask

  task automatic test_gt_partial();
    clear_queues();
    send_beat(3'd7, 8'd5, 8'd3, 1'b0);
    send_beat(3'd7, 8'd3, 8'd5, 1'b0);
    send_beat(3'd7, 8'd9, 8'd9, 1'b1);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'h01, 4'd3, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL gt_partial: got %0d words first=%h required 1 word %h", got_q.size(),
               got_q.size() ? got_q[0] : word_t'('0), {8'h01, 4'd3, 4'd1, 1'b1});
    end
  endtask

  task automatic test_opcode_sweep();
    clear_queues();
    for (int s = 0; s < 8; s++) send_beat(3'(s), 8'd4, 8'd4, s == 7);
    for (int s = 0; s < 8; s++) send_beat(3'(s), 8'd3, 8'd4, s == 7);
    drain();
    checks += 2;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL sweep_count: got %0d words required 2", got_q.size());
    end else begin
      if (got_q[0] !== {8'h36, 4'd8, 4'd4, 1'b1}) begin
        errors++; $display("FAIL sweep_word0: got %h required %h", got_q[0], {8'h36, 4'd8, 4'd4, 1'b1});
      end
      if (got_q[1] !== {8'h6A, 4'd8, 4'd4, 1'b1}) begin
        errors++; $display("FAIL sweep_word1: got %h required %h", got_q[1], {8'h6A, 4'd8, 4'd4, 1'b1});
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    out_ready = 1'b1;
    stall_cycles = 0;
    for (int i = 0; i < 3 * PACK; i++) begin
      send_beat(3'($urandom_range(0, 7)), N'($urandom), N'($urandom), i == 3 * PACK - 1);
    end
    checks++;
    if (stall_cycles != 0) begin errors++; $display("FAIL b2b_stalls: got %0d stall cycles required 0", stall_cycles); end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d words required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    bit stable = 1;
    word_t snap;
    logic [N-1:0] a, b;
    logic [2:0] s;
    clear_queues();
    out_ready = 1'b0;
    for (int i = 0; i < PACK - 1; i++) send_beat(3'($urandom_range(0, 7)), N'($urandom), N'($urandom), 1'b0);
    in_valid = 1'b1; in_last = 1'b0;
    for (int c = 0; c < 4 * PACK; c++) begin
      s = 3'($urandom_range(0, 7)); a = N'($urandom); b = N'($urandom);
      in_sel = s; in_a = a; in_b = b;
      @(negedge clk);
      if (!in_ready) break;
      @(posedge clk); #1;
      model_beat(pred(s, int'(a), int'(b)), 1'b0);
      accepts++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (accepts != PACK + 1) begin errors++; $display("FAIL bp_accepts: got %0d required %0d", accepts, PACK + 1); end
    snap = {out_mask, out_len, out_count, out_last};
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || {out_mask, out_len, out_count, out_last} !== snap) stable = 0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_hold: out=%h valid=%0b in_ready=%0b required %h/1/0", {out_mask, out_len, out_count, out_last}, out_valid, in_ready, snap); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_recover: got %0b required 1", in_ready); end
    drain();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() != 2) begin
      errors++; $display("FAIL bp_count: got %0d words required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random_stream();
    bit last;
    clear_queues();
    bp_mode = 1;
    for (int i = 0; i < 100; i++) begin
      last = (i == 99) || ($urandom_range(0, 5) == 0);
      send_beat(3'($urandom_range(0, 7)), N'($urandom_range(0, 7)), N'($urandom_range(0, 7)), last);
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d words required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
    $display("random stream: %0d words", got_q.size());
  endtask

  task automatic test_reset_mid();
    clear_queues();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(3'd1, N'($urandom), N'($urandom), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cur_bits.delete();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b required 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b required 1", in_ready); end
    send_beat(3'd1, 8'd0, 8'd0, 1'b0);
    send_beat(3'd0, 8'd0, 8'd0, 1'b0);
    send_beat(3'd1, 8'd0, 8'd0, 1'b1);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'h05, 4'd3, 4'd2, 1'b1}) begin
      errors++; $display("FAIL rstmid_word: got %0d words first=%h required 1 word %h", got_q.size(),
                         got_q.size() ? got_q[0] : word_t'('0), {8'h05, 4'd3, 4'd2, 1'b1});
    end
    clear_queues();
    out_ready = 1'b0;
    for (int i = 0; i < PACK + 2; i++) send_beat(3'd1, 8'd0, 8'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_queues();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || got_q.size() != 0) begin
      errors++; $display("FAIL rstbp_discard: valid=%0b words=%0d required 0/0", out_valid, got_q.size());
    end
  endtask

`ifdef CMP_PACK_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_queues();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(3'd1, 8'd0, 8'd0, i == 2);
    send_beat(3'd0, 8'd0, 8'd0, 1'b0);
    send_beat(3'd1, 8'd0, 8'd0, 1'b1);
    send_beat(3'd1, 8'd0, 8'd0, 1'b1);
    drain();
    checks += 2;
    if (stat_words !== 16'd3) begin errors++; $display("FAIL stat_words: got %0d required 3", stat_words); end
    if (stat_true !== 16'd5) begin errors++; $display("FAIL stat_true: got %0d required 5", stat_true); end
    for (int i = 0; i < 65540; i++) send_beat(3'd1, 8'd0, 8'd0, 1'b1);
    drain();
    checks += 2;
    if (stat_words !== 16'hFFFF) begin errors++; $display("FAIL stat_words_sat: got %h required FFFF", stat_words); end
    if (stat_true !== 16'hFFFF) begin errors++; $display("FAIL stat_true_sat: got %h required FFFF", stat_true); end
    clear_queues();
  endtask
`endif

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_eq_word();
    test_gt_partial();
    test_opcode_sweep();
    test_back_to_back();
    test_backpressure();
    test_random_stream();
    test_reset_mid();
`ifdef CMP_PACK_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
